// File: rtl/axi4_rd_slave.sv
// AXI4 read-channel responder (AR + R) backed by a word-addressed memory array.
// Optional AXI_RD_SLAVE_DECERR_EN: out-of-range beats return DECERR instead of aliasing modulo MEM_DEPTH.
module axi4_rd_slave #(
  parameter int    C_S_AXI_ID_WIDTH    = 1,
  parameter int    C_S_AXI_DATA_WIDTH  = 64,
  parameter int    C_S_AXI_ADDR_WIDTH  = 32,
  parameter int    C_S_AXI_RUSER_WIDTH = 1,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] MEM_BASE = C_S_AXI_ADDR_WIDTH'(32'h8000_0000),
  parameter int    MEM_DEPTH           = 1024,
  parameter string MEM_INIT_FILE       = ""
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETn,
  input  logic [C_S_AXI_ID_WIDTH-1:0]    S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]  S_AXI_ARADDR,
  input  logic [7:0]                     S_AXI_ARLEN,
  input  logic [2:0]                     S_AXI_ARSIZE,
  input  logic [1:0]                     S_AXI_ARBURST,
  input  logic [3:0]                     S_AXI_ARCACHE,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic [3:0]                     S_AXI_ARQOS,
  input  logic [3:0]                     S_AXI_ARREGION,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]    S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]  S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RLAST,
  output logic [C_S_AXI_RUSER_WIDTH-1:0] S_AXI_RUSER,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int IW = C_S_AXI_ID_WIDTH;
  localparam int WB = $clog2(DW / 8);
  localparam int XW = $clog2(MEM_DEPTH);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXI_RD_SLAVE_DECERR_EN
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [AW-1:0] DEPTH_A  = AW'(MEM_DEPTH);
`endif

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_e;

  logic [DW-1:0] mem [0:MEM_DEPTH-1];

  function automatic logic [AW-1:0] start_addr(input logic [AW-1:0] addr,
                                               input logic [2:0]    size,
                                               input logic [1:0]    burst);
    logic [AW-1:0] step;
    step = AW'(1) << size;
    if (burst == BURST_FIXED) begin
      start_addr = addr;
    end else begin
      start_addr = addr & ~(step - AW'(1));
    end
  endfunction

  // WRAP keeps the low bits inside a window of (len+1) beats aligned to its own size.
  function automatic logic [AW-1:0] next_beat_addr(input logic [AW-1:0] addr,
                                                   input logic [2:0]    size,
                                                   input logic [7:0]    len,
                                                   input logic [1:0]    burst);
    logic [AW-1:0] step;
    logic [AW-1:0] wmask;
    logic [AW-1:0] inc;
    step  = AW'(1) << size;
    wmask = ((AW'(len) + AW'(1)) << size) - AW'(1);
    inc   = (addr & ~(step - AW'(1))) + step;
    case (burst)
      BURST_FIXED: next_beat_addr = addr;
      BURST_WRAP:  next_beat_addr = (addr & ~wmask) | (inc & wmask);
      default:     next_beat_addr = inc;
    endcase
  endfunction

  function automatic logic burst_err(input logic [2:0] size,
                                     input logic [7:0] len,
                                     input logic [1:0] burst);
    logic err;
    if (burst == BURST_RSVD) begin
      err = 1'b1;
    end else if (burst == BURST_WRAP) begin
      err = !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    end else begin
      err = 1'b0;
    end
    if (size > 3'(WB)) begin
      err = 1'b1;
    end else begin
      err = err;
    end
    burst_err = err;
  endfunction

  state_e        state_q, state_d;
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  logic          rlast_q, rlast_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [IW-1:0] rid_q, rid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [2:0]    size_q, size_d;
  logic [1:0]    burst_q, burst_d;
  logic [7:0]    beat_q, beat_d;
  logic          err_q, err_d;

  logic          ar_hs_s, r_hs_s, load_s, fetch_err_s;
  logic [AW-1:0] fetch_addr_s, off_s, idx_full_s;
  logic [DW-1:0] word_s;
  logic          unused_s;

  // Next-state, beat sequencing and registered-output staging.
  always_comb begin
    state_d      = state_q;
    arready_d    = arready_q;
    rvalid_d     = rvalid_q;
    rlast_d      = rlast_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    rid_d        = rid_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    beat_d       = beat_q;
    err_d        = err_q;
    load_s       = 1'b0;
    fetch_addr_s = addr_q;
    fetch_err_s  = err_q;
    ar_hs_s      = S_AXI_ARVALID & arready_q;
    r_hs_s       = rvalid_q & S_AXI_RREADY;

    case (state_q)
      ST_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs_s) begin
          arready_d    = 1'b0;
          state_d      = ST_BURST;
          rid_d        = S_AXI_ARID;
          len_d        = S_AXI_ARLEN;
          size_d       = S_AXI_ARSIZE;
          burst_d      = S_AXI_ARBURST;
          fetch_err_s  = burst_err(S_AXI_ARSIZE, S_AXI_ARLEN, S_AXI_ARBURST);
          fetch_addr_s = start_addr(S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARBURST);
          err_d        = fetch_err_s;
          beat_d       = 8'd0;
          rvalid_d     = 1'b1;
          rlast_d      = (S_AXI_ARLEN == 8'd0);
          load_s       = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        arready_d = 1'b0;
        if (r_hs_s) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            fetch_addr_s = next_beat_addr(addr_q, size_q, len_q, burst_q);
            beat_d       = beat_q + 8'd1;
            rlast_d      = ((beat_q + 8'd1) == len_q);
            load_s       = 1'b1;
          end
        end else begin
          state_d = ST_BURST;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end
    endcase

    off_s      = fetch_addr_s - MEM_BASE;
    idx_full_s = off_s >> WB;
    word_s     = mem[idx_full_s[XW-1:0]];

    if (load_s) begin
      addr_d = fetch_addr_s;
      if (fetch_err_s) begin
        rresp_d = RESP_SLVERR;
        rdata_d = {DW{1'b0}};
      end
`ifdef AXI_RD_SLAVE_DECERR_EN
      else if (idx_full_s >= DEPTH_A) begin
        rresp_d = RESP_DECERR;
        rdata_d = {DW{1'b0}};
      end
`endif
      else begin
        rresp_d = RESP_OKAY;
        rdata_d = word_s;
      end
    end else begin
      addr_d = addr_q;
    end
  end

  // State and output registers; reset aborts any burst in flight.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETn) begin
    if (!S_AXI_ARESETn) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= {DW{1'b0}};
      rresp_q   <= 2'b00;
      rid_q     <= {IW{1'b0}};
      addr_q    <= {AW{1'b0}};
      len_q     <= 8'd0;
      size_q    <= 3'd0;
      burst_q   <= 2'b00;
      beat_q    <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
    end
  end

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RUSER   = {C_S_AXI_RUSER_WIDTH{1'b0}};

  assign unused_s = ^{S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARREGION, idx_full_s};

endmodule

// File: tb/tb_axi4_rd_slave.sv
// Directed bench for axi4_rd_slave: burst types, stalls, error responses, range handling, reset.
module tb_axi4_rd_slave;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] SLV = 2'b10;
  localparam logic [1:0] DEC = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:0]  arid = 1'b0;
  logic [31:0] araddr = 32'd0;
  logic [7:0]  arlen = 8'd0;
  logic [2:0]  arsize = 3'd0;
  logic [1:0]  arburst = 2'b00;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [0:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [0:0]  ruser;
  logic        rvalid;
  logic        rready = 1'b0;

  int total = 0;
  int bad   = 0;
  int       e_idx  [16];
  logic [1:0] e_resp [16];

  always #5 clk = ~clk;

  axi4_rd_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETn(rst_n),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
    .S_AXI_ARCACHE(4'd0), .S_AXI_ARPROT(3'd0), .S_AXI_ARQOS(4'd0), .S_AXI_ARREGION(4'd0),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RUSER(ruser), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  function automatic logic [63:0] exp_word(input int i);
    if (i == 0) return 64'hDEAD_BEEF_0123_4567;
    return {32'hCAFE_0000 + 32'(i), 32'h1000_0000 + 32'(i * 3)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_burst(input string tag, input logic [0:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [15:0] pat);
    int beat;
    int cyc;
    logic stalled;
    logic hs;
    logic [63:0] held;
    logic [63:0] exp_d;
    cyc = 0;
    while (!arready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_arready"}, 64'(arready), 64'd1);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk({tag, "_ar_drop"}, 64'(arready), 64'd0);
    beat = 0; cyc = 0; stalled = 1'b0; held = 64'd0;
    while (beat <= int'(len) && cyc < 600) begin
      chk($sformatf("%s_c%0d_rvalid", tag, cyc), 64'(rvalid), 64'd1);
      if (stalled) chk($sformatf("%s_c%0d_stable", tag, cyc), rdata, held);
      rready = pat[cyc % 16];
      held = rdata;
      hs = rvalid & rready;
      if (hs) begin
        exp_d = (e_idx[beat] < 0) ? 64'd0 : exp_word(e_idx[beat]);
        chk($sformatf("%s_b%0d_data", tag, beat), rdata, exp_d);
        chk($sformatf("%s_b%0d_resp", tag, beat), 64'(rresp), 64'(e_resp[beat]));
        chk($sformatf("%s_b%0d_last", tag, beat), 64'(rlast), 64'(beat == int'(len)));
        chk($sformatf("%s_b%0d_id", tag, beat), 64'(rid), 64'(id));
        chk($sformatf("%s_b%0d_ruser", tag, beat), 64'(ruser), 64'd0);
      end
      stalled = rvalid & ~rready;
      @(posedge clk); #1;
      if (hs) beat++;
      cyc++;
    end
    rready = 1'b0;
    chk({tag, "_beats"}, 64'(beat), 64'(len) + 64'd1);
    chk({tag, "_idle"}, 64'({arready, rvalid, rlast}), 64'b100);
  endtask

  initial begin
    #1;
    for (int i = 0; i < 1024; i++) dut.mem[i] = exp_word(i);
    #11;
    chk("rst_state", 64'({arready, rvalid, rlast, rid, rresp}), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arready_after_rst", 64'(arready), 64'd1);

    e_idx[0] = 0; e_resp[0] = OK;
    run_burst("single", 1'b1, 32'h8000_0000, 8'd0, 3'd3, 2'b01, 16'hFFFF);

    for (int i = 0; i < 4; i++) begin e_idx[i] = 2 + i; e_resp[i] = OK; end
    run_burst("incr_stall", 1'b0, 32'h8000_0010, 8'd3, 3'd3, 2'b01, 16'b1001_1001_1001_1001);

    e_idx[0] = 6; e_idx[1] = 7; e_idx[2] = 4; e_idx[3] = 5;
    for (int i = 0; i < 4; i++) e_resp[i] = OK;
    run_burst("wrap4", 1'b1, 32'h8000_0030, 8'd3, 3'd3, 2'b10, 16'hFFFF);

    for (int i = 0; i < 3; i++) begin e_idx[i] = -1; e_resp[i] = SLV; end
    run_burst("wrap_len2", 1'b0, 32'h8000_0000, 8'd2, 3'd3, 2'b10, 16'hFFFF);

    for (int i = 0; i < 8; i++) begin e_idx[i] = 1; e_resp[i] = OK; end
    run_burst("fixed8", 1'b1, 32'h8000_0008, 8'd7, 3'd3, 2'b00, 16'b0110_1101_1011_0111);

    for (int i = 0; i < 4; i++) begin e_idx[i] = -1; e_resp[i] = SLV; end
    run_burst("rsvd", 1'b1, 32'h8000_0020, 8'd3, 3'd3, 2'b11, 16'hFFFF);

    for (int i = 0; i < 2; i++) begin e_idx[i] = -1; e_resp[i] = SLV; end
    run_burst("size_big", 1'b0, 32'h8000_0040, 8'd1, 3'd4, 2'b01, 16'hFFFF);

    e_idx[0] = 0; e_idx[1] = 1; e_idx[2] = 1; e_idx[3] = 2;
    for (int i = 0; i < 4; i++) e_resp[i] = OK;
    run_burst("narrow", 1'b0, 32'h8000_0004, 8'd3, 3'd2, 2'b01, 16'hFFFF);

    e_idx[0] = 1023; e_resp[0] = OK;
`ifdef AXI_RD_SLAVE_DECERR_EN
    e_idx[1] = -1; e_resp[1] = DEC;
`else
    e_idx[1] = 0; e_resp[1] = OK;
`endif
    run_burst("oor_top", 1'b1, 32'h8000_1FF8, 8'd1, 3'd3, 2'b01, 16'hFFFF);

`ifdef AXI_RD_SLAVE_DECERR_EN
    e_idx[0] = -1; e_resp[0] = DEC;
`else
    e_idx[0] = 1023; e_resp[0] = OK;
`endif
    run_burst("below_base", 1'b0, 32'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 16'hFFFF);

    // Reset in the middle of an eight-beat burst.
    arid = 1'b1; araddr = 32'h8000_0000; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01;
    arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_beat2_data", rdata, exp_word(2));
    chk("mid_beat2_rvalid", 64'(rvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rvalid", 64'({rvalid, rlast, arready}), 64'd0);
    chk("async_rst_rdata", rdata, 64'd0);
    rready = 1'b0;
    #10 rst_n = 1'b1;
    #1;
    chk("pre_edge_arready", 64'(arready), 64'd0);
    @(posedge clk); #1;
    chk("post_rst_arready", 64'(arready), 64'd1);
    e_idx[0] = 3; e_resp[0] = OK;
    run_burst("post_rst", 1'b1, 32'h8000_0018, 8'd0, 3'd3, 2'b01, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
